// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch state encoding and instruction field ranges
// used by the fetch stage, Controller and AluController.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_REQ     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_HOLD    = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam int          PC_STEP    = 4;
  localparam int          OPCODE_MSB = 31;
  localparam int          OPCODE_LSB = 26;
  localparam int          FUNC_MSB   = 5;
  localparam int          FUNC_LSB   = 0;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register: owns the PC, talks req/ack to
// instruction memory, parks one instruction across stalls, applies redirects.
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              ifid_valid,
  output logic [DATA_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc4,
  output logic [5:0]        ifid_opcode,
  output logic [5:0]        ifid_func,
  output fetch_state_e      dbg_state
);

  // imem handshake: a word transfers in any cycle where imem_req && imem_ack.
  // imem_addr stays fixed from request start until that transfer completes.

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic [DATA_W-1:0] hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc4_q, hold_pc4_d;
  logic              ifid_valid_q, ifid_valid_d;
  logic [DATA_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0] ifid_pc4_q, ifid_pc4_d;

  logic              ack_eff;
  logic              accept;
  logic              start_req;
  logic              deliver;
  logic [DATA_W-1:0] deliver_instr;
  logic [ADDR_W-1:0] deliver_pc4;
  logic [ADDR_W-1:0] seq_pc;

  assign imem_req  = !reset && (state_q != ST_HOLD);
  assign imem_addr = req_addr_q;
  assign ack_eff   = imem_req && imem_ack;
  assign accept    = !stall && !flush;
  assign seq_pc    = req_addr_q + ADDR_W'(PC_STEP);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    hold_instr_d  = hold_instr_q;
    hold_pc4_d    = hold_pc4_q;
    start_req     = 1'b0;
    deliver       = 1'b0;
    deliver_instr = DATA_W'(NOP_INSTR);
    deliver_pc4   = '0;

    case (state_q)
      ST_REQ: begin
        if (ack_eff) begin
          if (redirect_valid) begin
            pc_d      = redirect_pc;
            start_req = 1'b1;
          end else if (accept) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            deliver_pc4   = seq_pc;
            pc_d          = seq_pc;
            start_req     = 1'b1;
          end else begin
            hold_instr_d = imem_rdata;
            hold_pc4_d   = seq_pc;
            pc_d         = seq_pc;
            state_d      = ST_HOLD;
          end
        end else if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = ST_DISCARD;
        end
      end
      ST_DISCARD: begin
        // Stale request must still complete; later redirects just retarget pc.
        if (redirect_valid) pc_d = redirect_pc;
        if (ack_eff) begin
          state_d   = ST_REQ;
          start_req = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect_valid) begin
          pc_d      = redirect_pc;
          state_d   = ST_REQ;
          start_req = 1'b1;
        end else if (accept) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr_q;
          deliver_pc4   = hold_pc4_q;
          state_d       = ST_REQ;
          start_req     = 1'b1;
        end
      end
      default: begin
        state_d   = ST_REQ;
        start_req = 1'b1;
      end
    endcase

    if (start_req) req_addr_d = pc_d;

    if (flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = DATA_W'(NOP_INSTR);
      ifid_pc4_d   = '0;
    end else if (stall) begin
      ifid_valid_d = ifid_valid_q;
      ifid_instr_d = ifid_instr_q;
      ifid_pc4_d   = ifid_pc4_q;
    end else begin
      ifid_valid_d = deliver;
      ifid_instr_d = deliver_instr;
      ifid_pc4_d   = deliver_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      hold_instr_q <= DATA_W'(NOP_INSTR);
      hold_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= DATA_W'(NOP_INSTR);
      ifid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  assign ifid_valid  = ifid_valid_q;
  assign ifid_instr  = ifid_instr_q;
  assign ifid_pc4    = ifid_pc4_q;
  assign ifid_opcode = ifid_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign ifid_func   = ifid_instr_q[FUNC_MSB:FUNC_LSB];
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table for the pipeline corner cases,
// then random stall/flush/redirect/ack traffic against a queue-based model.
module tb_fetch_stage;
  import pipeline_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  ifid_opcode;
  logic [5:0]  ifid_func;
  fetch_state_e dbg_state;

  always #5 clk = ~clk;

  fetch_stage #(.ADDR_W(32), .DATA_W(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ifid_valid(ifid_valid), .ifid_instr(ifid_instr),
    .ifid_pc4(ifid_pc4), .ifid_opcode(ifid_opcode), .ifid_func(ifid_func),
    .dbg_state(dbg_state)
  );

  // ---------------- checking helpers ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] f(input logic [31:0] a);
    return 32'hA000_0000 | a;
  endfunction

  typedef struct {
    logic        rst, stl, fls, ack, rdv;
    logic [31:0] rpc, rdata;
    logic        req;
    logic [31:0] addr;
    logic        v;
    logic [31:0] instr, pc4;
  } vec_t;

  vec_t vec_q[$];

  task automatic add(input logic rst, stl, fls, ack, rdv, input logic [31:0] rpc, rdata,
                     input logic req, input logic [31:0] addr,
                     input logic v, input logic [31:0] instr, pc4);
    vec_t e;
    e.rst = rst; e.stl = stl; e.fls = fls; e.ack = ack; e.rdv = rdv;
    e.rpc = rpc; e.rdata = rdata; e.req = req; e.addr = addr;
    e.v = v; e.instr = instr; e.pc4 = pc4;
    vec_q.push_back(e);
  endtask

  // ---------------- reference model state ----------------
  logic [31:0] m_pc, m_req_addr, m_instr, m_pc4;
  logic        m_drop, m_v;
  logic [63:0] m_buf_q[$];          // {pc4, instr}; non-empty means fetch is parked
  logic [65:0] exp_q[$];            // {check_pc4, valid, instr, pc4}

  initial begin
    vec_t v;
    logic r_rst, r_stl, r_fls, r_rdv, r_ack, m_req, got, had_buf, deliver, acc;
    logic [31:0] r_rpc, r_rdata;
    logic [63:0] d;
    logic [65:0] e;

    // Columns: rst stl fls ack rdv rpc rdata | req addr | v instr pc4
    add(1,0,0,0,0, 0, 0,                 0, 0,            0, 0, 0);
    add(1,0,0,1,0, 0, f(0),              0, 0,            0, 0, 0);
    // zero-wait fetch stream
    add(0,0,0,1,0, 0, f(0),              1, 0,            1, f(0), 4);
    add(0,0,0,1,0, 0, f(4),              1, 4,            1, f(4), 8);
    add(0,0,0,1,0, 0, f(8),              1, 8,            1, f(8), 12);
    add(1,0,0,0,0, 0, 0,                 0, 0,            0, 0, 0);
    // stall across an ack: instruction parks, req drops, delivered on release
    add(0,0,0,1,0, 0, f(0),              1, 0,            1, f(0), 4);
    add(0,0,0,1,0, 0, f(4),              1, 4,            1, f(4), 8);
    add(0,1,0,1,0, 0, f(8),              1, 8,            1, f(4), 8);
    add(0,1,0,0,0, 0, 0,                 0, 0,            1, f(4), 8);
    add(0,1,0,0,0, 0, 0,                 0, 0,            1, f(4), 8);
    add(0,0,0,0,0, 0, 0,                 0, 0,            1, f(8), 12);
    add(0,0,0,1,0, 0, f(12),             1, 12,           1, f(12), 16);
    add(1,0,0,0,0, 0, 0,                 0, 0,            0, 0, 0);
    // slow memory with redirect while a request is pending
    add(0,0,0,1,0, 0, f(0),              1, 0,            1, f(0), 4);
    add(0,0,0,1,0, 0, f(4),              1, 4,            1, f(4), 8);
    add(0,0,0,0,0, 0, 0,                 1, 8,            0, 0, 0);
    add(0,0,0,0,1, 32'h40, 0,            1, 8,            0, 0, 0);
    add(0,0,0,1,0, 0, f(8),              1, 8,            0, 0, 0);
    add(0,0,0,0,0, 0, 0,                 1, 32'h40,       0, 0, 0);
    add(0,0,0,1,0, 0, f(32'h40),         1, 32'h40,       1, f(32'h40), 32'h44);
    // flush + redirect on the ack cycle
    add(0,0,1,1,1, 32'h100, f(32'h44),   1, 32'h44,       0, 0, 0);
    add(0,0,0,1,0, 0, f(32'h100),        1, 32'h100,      1, f(32'h100), 32'h104);
    // reset while discarding, ack arrives during reset
    add(0,0,0,0,1, 32'h200, 0,           1, 32'h104,      0, 0, 0);
    add(1,0,0,1,0, 0, f(32'h104),        0, 0,            0, 0, 0);
    add(0,0,0,0,0, 0, 0,                 1, RST_PC,       0, 0, 0);
    add(0,0,0,0,0, 0, 0,                 1, RST_PC,       0, 0, 0);
    add(0,0,0,1,0, 0, f(0),              1, 0,            1, f(0), 4);
    // redirect + stall while parked
    add(0,1,0,1,0, 0, f(4),              1, 4,            1, f(0), 4);
    add(0,1,0,0,1, 32'h300, 0,           0, 0,            1, f(0), 4);
    add(0,1,0,0,0, 0, 0,                 1, 32'h300,      1, f(0), 4);
    add(0,0,0,1,0, 0, f(32'h300),        1, 32'h300,      1, f(32'h300), 32'h304);
    // flush alone, then address wrap past all-ones
    add(0,0,1,0,0, 0, 0,                 1, 32'h304,      0, 0, 0);
    add(0,0,0,0,1, 32'hFFFF_FFFC, 0,     1, 32'h304,      0, 0, 0);
    add(0,0,0,1,0, 0, f(32'h304),        1, 32'h304,      0, 0, 0);
    add(0,0,0,1,0, 0, 32'hFFFF_FFFC,     1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0);
    add(0,0,0,1,0, 0, f(0),              1, 0,            1, f(0), 4);
    // flush without redirect on ack: instruction parks, flush clears IF/ID
    add(0,0,1,1,0, 0, f(4),              1, 4,            0, 0, 0);
    add(0,0,0,0,0, 0, 0,                 0, 0,            1, f(4), 8);
    add(0,0,0,1,0, 0, f(8),              1, 8,            1, f(8), 12);

    for (int i = 0; i < vec_q.size(); i++) begin
      v = vec_q[i];
      @(negedge clk);
      reset = v.rst; stall = v.stl; flush = v.fls; imem_ack = v.ack;
      redirect_valid = v.rdv; redirect_pc = v.rpc; imem_rdata = v.rdata;
      #1;
      chk($sformatf("vec%0d imem_req", i), {63'd0, imem_req}, {63'd0, v.req});
      if (v.req) chk($sformatf("vec%0d imem_addr", i), {32'd0, imem_addr}, {32'd0, v.addr});
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d ifid_valid", i), {63'd0, ifid_valid}, {63'd0, v.v});
      chk($sformatf("vec%0d ifid_instr", i), {32'd0, ifid_instr}, {32'd0, v.instr});
      chk($sformatf("vec%0d ifid_opcode", i), {58'd0, ifid_opcode}, {58'd0, v.instr[31:26]});
      chk($sformatf("vec%0d ifid_func", i), {58'd0, ifid_func}, {58'd0, v.instr[5:0]});
      if (v.v || v.fls || v.rst)
        chk($sformatf("vec%0d ifid_pc4", i), {32'd0, ifid_pc4}, {32'd0, v.pc4});
      if (i == 0) chk("reset_state", {62'd0, dbg_state}, {62'd0, ST_REQ});
    end

    // ---------------- random traffic vs model ----------------
    m_pc = RST_PC; m_req_addr = RST_PC; m_drop = 1'b0; m_v = 1'b0;
    m_instr = '0; m_pc4 = '0;
    for (int c = 0; c < 4000; c++) begin
      r_rst = (c < 2) || ($urandom_range(0, 199) == 0);
      r_stl = ($urandom_range(0, 9) < 2);
      r_fls = ($urandom_range(0, 19) == 0);
      r_rdv = ($urandom_range(0, 9) == 0);
      r_rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      r_ack = ($urandom_range(0, 9) < 6);
      r_rdata = $urandom();

      @(negedge clk);
      reset = r_rst; stall = r_stl; flush = r_fls; redirect_valid = r_rdv;
      redirect_pc = r_rpc; imem_ack = r_ack; imem_rdata = r_rdata;
      #1;
      m_req = !r_rst && (m_buf_q.size() == 0);
      chk("rnd imem_req", {63'd0, imem_req}, {63'd0, m_req});
      if (m_req) chk("rnd imem_addr", {32'd0, imem_addr}, {32'd0, m_req_addr});

      got = m_req && r_ack;
      had_buf = (m_buf_q.size() != 0);
      deliver = 1'b0;
      d = '0;
      if (r_rst) begin
        m_pc = RST_PC; m_req_addr = RST_PC; m_drop = 1'b0; m_buf_q.delete();
        m_v = 1'b0; m_instr = '0; m_pc4 = '0;
      end else begin
        acc = !r_stl && !r_fls;
        if (had_buf) begin
          if (r_rdv) begin
            m_buf_q.delete();
            m_pc = r_rpc;
          end else if (acc) begin
            d = m_buf_q.pop_front();
            deliver = 1'b1;
          end
        end else if (got) begin
          if (m_drop) begin
            m_drop = 1'b0;
            if (r_rdv) m_pc = r_rpc;
          end else if (r_rdv) begin
            m_pc = r_rpc;
          end else begin
            m_pc = m_req_addr + 32'd4;
            if (acc) begin
              d = {m_pc, r_rdata};
              deliver = 1'b1;
            end else begin
              m_buf_q.push_back({m_pc, r_rdata});
            end
          end
        end else if (r_rdv) begin
          m_pc = r_rpc;
          m_drop = 1'b1;
        end
        if (!m_drop && m_buf_q.size() == 0 && (got || had_buf)) m_req_addr = m_pc;

        if (r_fls) begin
          m_v = 1'b0; m_instr = '0; m_pc4 = '0;
        end else if (!r_stl) begin
          m_v = deliver; m_instr = d[31:0]; m_pc4 = d[63:32];
        end
      end
      exp_q.push_back({(m_v || r_fls || r_rst), m_v, m_instr, m_pc4});

      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("rnd ifid_valid", {63'd0, ifid_valid}, {63'd0, e[64]});
      chk("rnd ifid_instr", {32'd0, ifid_instr}, {32'd0, e[63:32]});
      chk("rnd ifid_opcode", {58'd0, ifid_opcode}, {58'd0, e[63:58]});
      chk("rnd ifid_func", {58'd0, ifid_func}, {58'd0, e[37:32]});
      if (e[65]) chk("rnd ifid_pc4", {32'd0, ifid_pc4}, {32'd0, e[31:0]});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
